// File: rtl/stream_mon_pkg.sv
// Shared types and the width-generic increment helper for the stream performance monitor.
package stream_mon_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } chan_state_e;

    localparam int unsigned MAX_CNT_W  = 64;
    localparam int unsigned N_CNT      = 5;
    localparam int unsigned CNT_XFER   = 0;
    localparam int unsigned CNT_BUSY   = 1;
    localparam int unsigned CNT_STALL  = 2;
    localparam int unsigned CNT_STARVE = 3;
    localparam int unsigned CNT_FRAMES = 4;
    localparam int unsigned SH_MAXLEN  = 5;
    localparam int unsigned N_SH       = 6;

    // Increment the low `width` bits of val; at all-ones either hold or wrap, and report the hit.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input  logic [MAX_CNT_W-1:0] val,
        input  int unsigned          width,
        input  logic                 saturate,
        output logic                 hit_limit
    );
        logic [MAX_CNT_W-1:0] mask;
        logic [MAX_CNT_W-1:0] nxt;
        mask = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
        if ((val & mask) == mask) begin
            hit_limit = 1'b1;
            nxt       = saturate ? mask : {MAX_CNT_W{1'b0}};
        end else begin
            hit_limit = 1'b0;
            nxt       = (val + {{(MAX_CNT_W-1){1'b0}}, 1'b1}) & mask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stream_mon_chan.sv
// One observed stream: frame FSM, five event counters, frame-length tracking,
// sticky overflow flag and the snapshot shadow registers.
module stream_mon_chan
    import stream_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic             last_i,
    input  logic             clear_i,
    input  logic             snap_i,
    output logic             in_frame_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] sh_xfer_o,
    output logic [CNT_W-1:0] sh_busy_o,
    output logic [CNT_W-1:0] sh_stall_o,
    output logic [CNT_W-1:0] sh_starve_o,
    output logic [CNT_W-1:0] sh_frames_o,
    output logic [CNT_W-1:0] sh_max_len_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q     [N_CNT];
    logic [CNT_W-1:0] cnt_d     [N_CNT];
    logic [CNT_W-1:0] inc_val_s [N_CNT];
    logic [CNT_W-1:0] live_s    [N_SH];
    logic [CNT_W-1:0] shadow_q  [N_SH];
    logic [CNT_W-1:0] cur_len_q, cur_len_d;
    logic [CNT_W-1:0] max_len_q, max_len_d;
    logic [CNT_W-1:0] len_inc_s;
    logic [N_CNT-1:0] ev_s;
    logic [N_CNT-1:0] inc_hit_s;
    logic             ovf_q, ovf_d;
    logic             hs_s, frame_s, len_hit_s;

    // Per-cycle event decode.
    always_comb begin
        hs_s               = valid_i & ready_i;
        frame_s            = (state_q == IN_FRAME);
        ev_s               = {N_CNT{1'b0}};
        ev_s[CNT_XFER]     = hs_s;
        ev_s[CNT_BUSY]     = frame_s | hs_s;
        ev_s[CNT_STALL]    = valid_i & ~ready_i;
        ev_s[CNT_STARVE]   = frame_s & ~valid_i;
        ev_s[CNT_FRAMES]   = hs_s & last_i;
    end

    // Counter next state; clear wins over any event in the same cycle.
    always_comb begin
        inc_hit_s = {N_CNT{1'b0}};
        for (int i = 0; i < int'(N_CNT); i++) begin
            inc_val_s[i] = CNT_W'(sat_inc(MAX_CNT_W'(cnt_q[i]), CNT_W, SATURATE, inc_hit_s[i]));
            if (clear_i) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (ev_s[i]) begin
                cnt_d[i] = inc_val_s[i];
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Frame FSM and length tracking; lengths always saturate, and clear leaves an open frame running.
    always_comb begin
        len_inc_s = CNT_W'(sat_inc(MAX_CNT_W'(cur_len_q), CNT_W, 1'b1, len_hit_s));
        if (hs_s && last_i) begin
            state_d   = IDLE;
            cur_len_d = {CNT_W{1'b0}};
        end else if (hs_s) begin
            state_d   = IN_FRAME;
            cur_len_d = len_inc_s;
        end else begin
            state_d   = state_q;
            cur_len_d = cur_len_q;
        end
        if (clear_i) begin
            max_len_d = {CNT_W{1'b0}};
        end else if (hs_s && last_i && (len_inc_s > max_len_q)) begin
            max_len_d = len_inc_s;
        end else begin
            max_len_d = max_len_q;
        end
        if (clear_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (|(ev_s & inc_hit_s)) | (hs_s & last_i & len_hit_s);
        end
    end

    // Live state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_len_q <= {CNT_W{1'b0}};
            max_len_q <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
            for (int i = 0; i < int'(N_CNT); i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            max_len_q <= max_len_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < int'(N_CNT); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Values the shadows capture: whatever the live registers hold before the snap edge.
    always_comb begin
        for (int i = 0; i < int'(N_CNT); i++) begin
            live_s[i] = cnt_q[i];
        end
        live_s[SH_MAXLEN] = max_len_q;
    end

    // Shadow registers, loaded atomically on snap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_SH); i++) begin
                shadow_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < int'(N_SH); i++) begin
                if (snap_i) begin
                    shadow_q[i] <= live_s[i];
                end else begin
                    shadow_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign in_frame_o   = (state_q == IN_FRAME);
    assign ovf_o        = ovf_q;
    assign sh_xfer_o    = shadow_q[CNT_XFER];
    assign sh_busy_o    = shadow_q[CNT_BUSY];
    assign sh_stall_o   = shadow_q[CNT_STALL];
    assign sh_starve_o  = shadow_q[CNT_STARVE];
    assign sh_frames_o  = shadow_q[CNT_FRAMES];
    assign sh_max_len_o = shadow_q[SH_MAXLEN];

endmodule

// File: rtl/stream_perf_monitor.sv
// Passive multi-stream performance monitor: per-channel counters with atomic snapshot
// and a channel-select readout mux.
module stream_perf_monitor
    import stream_mon_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1,
    localparam int unsigned SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  valid,
    input  logic [N_CH-1:0]  ready,
    input  logic [N_CH-1:0]  last,
    input  logic             clear,
    input  logic             snap,
    input  logic [SEL_W-1:0] sel,
    output logic             snap_done,
    output logic [CNT_W-1:0] rd_xfer,
    output logic [CNT_W-1:0] rd_busy,
    output logic [CNT_W-1:0] rd_stall,
    output logic [CNT_W-1:0] rd_starve,
    output logic [CNT_W-1:0] rd_frames,
    output logic [CNT_W-1:0] rd_max_len,
    output logic [N_CH-1:0]  in_frame,
    output logic [N_CH-1:0]  ovf
);

    logic [CNT_W-1:0] sh_xfer_s    [N_CH];
    logic [CNT_W-1:0] sh_busy_s    [N_CH];
    logic [CNT_W-1:0] sh_stall_s   [N_CH];
    logic [CNT_W-1:0] sh_starve_s  [N_CH];
    logic [CNT_W-1:0] sh_frames_s  [N_CH];
    logic [CNT_W-1:0] sh_max_len_s [N_CH];
    logic             snap_done_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        stream_mon_chan #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_i      (valid[g]),
            .ready_i      (ready[g]),
            .last_i       (last[g]),
            .clear_i      (clear),
            .snap_i       (snap),
            .in_frame_o   (in_frame[g]),
            .ovf_o        (ovf[g]),
            .sh_xfer_o    (sh_xfer_s[g]),
            .sh_busy_o    (sh_busy_s[g]),
            .sh_stall_o   (sh_stall_s[g]),
            .sh_starve_o  (sh_starve_s[g]),
            .sh_frames_o  (sh_frames_s[g]),
            .sh_max_len_o (sh_max_len_s[g])
        );
    end

    // Snapshot acknowledge, one cycle after snap is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_done_q <= 1'b0;
        end else begin
            snap_done_q <= snap;
        end
    end

    assign snap_done = snap_done_q;

    // Readout mux; selects beyond the last channel read zero.
    always_comb begin
        if (32'(sel) < N_CH) begin
            rd_xfer    = sh_xfer_s[sel];
            rd_busy    = sh_busy_s[sel];
            rd_stall   = sh_stall_s[sel];
            rd_starve  = sh_starve_s[sel];
            rd_frames  = sh_frames_s[sel];
            rd_max_len = sh_max_len_s[sel];
        end else begin
            rd_xfer    = {CNT_W{1'b0}};
            rd_busy    = {CNT_W{1'b0}};
            rd_stall   = {CNT_W{1'b0}};
            rd_starve  = {CNT_W{1'b0}};
            rd_frames  = {CNT_W{1'b0}};
            rd_max_len = {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Directed bench: per-cycle vector table plus readout table on a 3-channel monitor,
// and hand-written sequences for clear/snap interplay, overflow and async reset.
module tb_stream_perf_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid, ready, last;
    logic        clear, snap;
    logic [1:0]  sel;
    logic        snap_done;
    logic [31:0] rd_xfer, rd_busy, rd_stall, rd_starve, rd_frames, rd_max_len;
    logic [2:0]  in_frame, ovf;

    logic        v1, r1, l1, clr1, snp1;
    logic        a_sd, b_sd, a_if, b_if, a_ovf, b_ovf;
    logic [3:0]  a_xfer, a_busy, a_stall, a_starve, a_frames, a_max;
    logic [3:0]  b_xfer, b_busy, b_stall, b_starve, b_frames, b_max;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] v;
        logic [2:0] r;
        logic [2:0] l;
        logic       clr;
        logic       snp;
        logic [2:0] exp_if;
        logic       exp_sd;
    } vec_t;

    typedef struct {
        logic [1:0]  s;
        logic [31:0] x, b, st, sv, f, m;
    } rd_t;

    vec_t vecs[$];
    rd_t  rds[$];

    always #5 clk = ~clk;

    stream_perf_monitor #(.N_CH(3), .CNT_W(32), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .last(last),
        .clear(clear), .snap(snap), .sel(sel), .snap_done(snap_done),
        .rd_xfer(rd_xfer), .rd_busy(rd_busy), .rd_stall(rd_stall), .rd_starve(rd_starve),
        .rd_frames(rd_frames), .rd_max_len(rd_max_len), .in_frame(in_frame), .ovf(ovf)
    );

    stream_perf_monitor #(.N_CH(1), .CNT_W(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid(v1), .ready(r1), .last(l1),
        .clear(clr1), .snap(snp1), .sel(1'b0), .snap_done(a_sd),
        .rd_xfer(a_xfer), .rd_busy(a_busy), .rd_stall(a_stall), .rd_starve(a_starve),
        .rd_frames(a_frames), .rd_max_len(a_max), .in_frame(a_if), .ovf(a_ovf)
    );

    stream_perf_monitor #(.N_CH(1), .CNT_W(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .valid(v1), .ready(r1), .last(l1),
        .clear(clr1), .snap(snp1), .sel(1'b0), .snap_done(b_sd),
        .rd_xfer(b_xfer), .rd_busy(b_busy), .rd_stall(b_stall), .rd_starve(b_starve),
        .rd_frames(b_frames), .rd_max_len(b_max), .in_frame(b_if), .ovf(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [1:0] s,
                            input logic [31:0] x, b, st, sv, f, m);
        sel = s;
        #1;
        chk({tag, ".xfer"},    rd_xfer,    x);
        chk({tag, ".busy"},    rd_busy,    b);
        chk({tag, ".stall"},   rd_stall,   st);
        chk({tag, ".starve"},  rd_starve,  sv);
        chk({tag, ".frames"},  rd_frames,  f);
        chk({tag, ".max_len"}, rd_max_len, m);
    endtask

    task automatic addv(input logic [2:0] v, r, l, input logic clr, snp,
                        input logic [2:0] eif, input logic esd);
        vec_t t;
        t.v = v; t.r = r; t.l = l; t.clr = clr; t.snp = snp; t.exp_if = eif; t.exp_sd = esd;
        vecs.push_back(t);
    endtask

    task automatic addr(input logic [1:0] s, input logic [31:0] x, b, st, sv, f, m);
        rd_t t;
        t.s = s; t.x = x; t.b = b; t.st = st; t.sv = sv; t.f = f; t.m = m;
        rds.push_back(t);
    endtask

    task automatic idle();
        valid = 3'b000; ready = 3'b000; last = 3'b000; clear = 1'b0; snap = 1'b0;
    endtask

    task automatic beat(input logic [2:0] ch, input logic is_last);
        valid = ch; ready = ch; last = is_last ? ch : 3'b000;
        tick();
    endtask

    task automatic do_snap();
        idle();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        sel = 2'd0;
        v1 = 1'b0; r1 = 1'b0; l1 = 1'b0; clr1 = 1'b0; snp1 = 1'b0;

        // Stimulus table: ch0 4-beat frame, snap, ch1 stalled/starved frame,
        // ch2 one-beat frames and ignored 'last', then back-to-back snaps.
        addv(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        addv(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        addv(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        addv(3'b001, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
        addv(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0);
        addv(3'b010, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            addv(3'b100, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0);
        end
        addv(3'b100, 3'b000, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0);
        addv(3'b000, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1);
        addv(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);

        addr(2'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd1, 32'd4);
        addr(2'd1, 32'd3, 32'd8, 32'd2, 32'd3, 32'd1, 32'd3);
        addr(2'd2, 32'd5, 32'd5, 32'd1, 32'd0, 32'd5, 32'd1);
        addr(2'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        #12;
        check_rd("reset", 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("reset.in_frame",  32'(in_frame),  32'd0);
        chk("reset.snap_done", 32'(snap_done), 32'd0);
        chk("reset.ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            valid = vecs[i].v; ready = vecs[i].r; last = vecs[i].l;
            clear = vecs[i].clr; snap = vecs[i].snp;
            tick();
            chk($sformatf("vec%0d.in_frame", i),  32'(in_frame),  32'(vecs[i].exp_if));
            chk($sformatf("vec%0d.snap_done", i), 32'(snap_done), 32'(vecs[i].exp_sd));
        end
        idle();
        for (int i = 0; i < rds.size(); i++) begin
            check_rd($sformatf("rd_sel%0d", rds[i].s), rds[i].s,
                     rds[i].x, rds[i].b, rds[i].st, rds[i].sv, rds[i].f, rds[i].m);
        end
        chk("table.ovf", 32'(ovf), 32'd0);

        // snap and clear together after 7 beats, then 2 more beats and snap.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 7; k++) begin
            beat(3'b001, k == 6);
        end
        idle();
        snap = 1'b1; clear = 1'b1;
        tick();
        snap = 1'b0; clear = 1'b0;
        chk("snapclr.snap_done", 32'(snap_done), 32'd1);
        check_rd("snapclr1.ch0", 2'd0, 32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd7);
        check_rd("snapclr1.ch1", 2'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        beat(3'b001, 1'b0);
        beat(3'b001, 1'b1);
        do_snap();
        check_rd("snapclr2.ch0", 2'd0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd1, 32'd2);

        // clear in the middle of an open frame on ch1.
        beat(3'b010, 1'b0);
        beat(3'b010, 1'b0);
        chk("clrmid.open", 32'(in_frame), 32'd2);
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrmid.kept", 32'(in_frame), 32'd2);
        beat(3'b010, 1'b1);
        chk("clrmid.closed", 32'(in_frame), 32'd0);
        do_snap();
        check_rd("clrmid.ch1", 2'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd3);

        // 20 one-beat frames into 4-bit counters: saturating vs wrapping.
        v1 = 1'b1; r1 = 1'b1; l1 = 1'b1;
        repeat (20) tick();
        v1 = 1'b0; r1 = 1'b0; l1 = 1'b0;
        snp1 = 1'b1;
        tick();
        snp1 = 1'b0;
        chk("sat.xfer",    32'(a_xfer),   32'd15);
        chk("sat.busy",    32'(a_busy),   32'd15);
        chk("sat.frames",  32'(a_frames), 32'd15);
        chk("sat.max_len", 32'(a_max),    32'd1);
        chk("sat.stall",   32'(a_stall),  32'd0);
        chk("sat.starve",  32'(a_starve), 32'd0);
        chk("sat.ovf",     32'(a_ovf),    32'd1);
        chk("sat.snap_done", 32'(a_sd),   32'd1);
        chk("wrap.xfer",   32'(b_xfer),   32'd4);
        chk("wrap.busy",   32'(b_busy),   32'd4);
        chk("wrap.frames", 32'(b_frames), 32'd4);
        chk("wrap.max_len", 32'(b_max),   32'd1);
        chk("wrap.stall",  32'(b_stall),  32'd0);
        chk("wrap.starve", 32'(b_starve), 32'd0);
        chk("wrap.ovf",    32'(b_ovf),    32'd1);
        chk("wrap.snap_done", 32'(b_sd),  32'd1);
        chk("small.in_frame", 32'({a_if, b_if}), 32'd0);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("sat.ovf_cleared",  32'(a_ovf), 32'd0);
        chk("wrap.ovf_cleared", 32'(b_ovf), 32'd0);
        chk("sat.shadow_held",  32'(a_xfer), 32'd15);

        // Asynchronous reset between edges in the middle of a frame.
        beat(3'b001, 1'b0);
        beat(3'b001, 1'b0);
        do_snap();
        chk("prerst.in_frame", 32'(in_frame), 32'd1);
        check_rd("prerst", 2'd0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        check_rd("inrst", 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("inrst.in_frame",  32'(in_frame),  32'd0);
        chk("inrst.snap_done", 32'(snap_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(3'b001, 1'b0);
        beat(3'b001, 1'b1);
        do_snap();
        check_rd("postrst", 2'd0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd1, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
